seg_scan_driver: RTL and testbench

- Time-multiplexed driver for a DIGITS-wide hex seven-segment display on a shared segment bus.
- Latches a packed hex word and per-digit decimal points, then scans one digit at a time at a programmable rate.
- Provides optional leading-zero blanking and per-digit enable.
- Frame-synchronous update prevents tearing. Sits between the display-data producer and the board segment/anode pins.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_scan_driver_hex2seg.sv | 12 +
 rtl/seg_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment width,
// hex decode table, blank pattern and the segment polarity helper.
package seg_pkg;

   localparam int SEG_W = 7;

   // Segment order {g,f,e,d,c,b,a}, bit0 = a, active-high (lit = 1)
   localparam logic [SEG_W-1:0] HEX_SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   // Convert an active-high segment pattern to the board's pin polarity
   function automatic logic [SEG_W-1:0] seg_apply_pol(input logic [SEG_W-1:0] seg,
                                                      input logic             active_high);
      return active_high ? seg : ~seg;
   endfunction

endpackage

// File: rtl/seg_scan_driver_hex2seg.sv
// Combinational hex nibble to seven-segment decode (active-high pattern).
module hex2seg
   import seg_pkg::*;
(
   input  logic [3:0]       i_nib,
   output logic [SEG_W-1:0] o_seg
);

   // Table lookup; polarity is applied by the caller
   assign o_seg = HEX_SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex seven-segment driver. A pending register takes
// load data at any time; it is promoted to the active register only at the
// frame boundary so a frame is never drawn from mixed data.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS          = 8,
   parameter int CLK_DIV         = 50000,
   parameter int SEG_ACTIVE_HIGH = 1,
   parameter int AN_ACTIVE_HIGH  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  lz_blank,
   input  logic                  load,
   output logic [SEG_W-1:0]      seg_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = $clog2(CLK_DIV);

   localparam logic                  SEG_HI     = (SEG_ACTIVE_HIGH != 0);
   localparam logic [SEG_W-1:0]      SEG_IDLE   = seg_apply_pol(SEG_BLANK, SEG_HI);
   localparam logic                  DP_IDLE    = ~SEG_HI;
   localparam logic [DIGITS-1:0]     AN_IDLE    = (AN_ACTIVE_HIGH != 0) ? '0 : '1;

   logic [CNT_W-1:0]    r_div_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic                r_frame_done;

   logic [4*DIGITS-1:0] r_pend_data;
   logic [DIGITS-1:0]   r_pend_dp;
   logic [DIGITS-1:0]   r_pend_en;
   logic                r_pend_valid;

   logic [4*DIGITS-1:0] r_act_data;
   logic [DIGITS-1:0]   r_act_dp;
   logic [DIGITS-1:0]   r_act_en;

   logic [SEG_W-1:0]    r_seg;
   logic                r_dp;
   logic [DIGITS-1:0]   r_an;

   logic                w_tc;
   logic                w_pre_tc;
   logic                w_last_idx;
   logic                w_frame_end;
   logic [DIGITS-1:0]   w_lz_mask;
   logic [3:0]          w_nib;
   logic [SEG_W-1:0]    w_seg_raw;
   logic                w_blank;
   logic                w_dp_on;
   logic [DIGITS-1:0]   w_onehot;

   assign w_tc        = (r_div_cnt == CNT_W'(CLK_DIV - 1));
   assign w_pre_tc    = (r_div_cnt == CNT_W'(CLK_DIV - 2));
   assign w_last_idx  = (r_idx == IDX_W'(DIGITS - 1));
   assign w_frame_end = w_tc && w_last_idx;

   // Divider and digit index; index advances on each divider wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
         r_idx     <= '0;
      end else if (w_tc) begin
         r_div_cnt <= '0;
         r_idx     <= w_last_idx ? '0 : r_idx + 1'b1;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   // Registered frame_done is set one cycle early so it is high exactly in the wrap cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_pre_tc && w_last_idx;
      end
   end

   // Pending capture and frame-boundary commit; commit uses pre-load pending contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_data  <= '0;
         r_pend_dp    <= '0;
         r_pend_en    <= '0;
         r_pend_valid <= 1'b0;
         r_act_data   <= '0;
         r_act_dp     <= '0;
         r_act_en     <= '0;
      end else begin
         if (w_frame_end && r_pend_valid) begin
            r_act_data   <= r_pend_data;
            r_act_dp     <= r_pend_dp;
            r_act_en     <= r_pend_en;
            r_pend_valid <= 1'b0;
         end
         if (load) begin
            r_pend_data  <= data_in;
            r_pend_dp    <= dp_in;
            r_pend_en    <= digit_en;
            r_pend_valid <= 1'b1;
         end
      end
   end

   // Leading-zero mask: walk from the top digit down, disabled digits do not break the zero run
   always_comb begin
      logic v_zero_run;
      w_lz_mask  = '0;
      v_zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_zero_run   = v_zero_run && (!r_act_en[i] || (r_act_data[4*i +: 4] == 4'h0));
         w_lz_mask[i] = lz_blank && (i != 0) && v_zero_run;
      end
   end

   assign w_nib    = r_act_data[{r_idx, 2'b00} +: 4];
   assign w_blank  = !r_act_en[r_idx] || w_lz_mask[r_idx];
   assign w_dp_on  = !w_blank && r_act_dp[r_idx];
   assign w_onehot = DIGITS'(1) << r_idx;

   hex2seg u_hex2seg (
      .i_nib (w_nib),
      .o_seg (w_seg_raw)
   );

   // Output register: segments, dp and anode all update on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= SEG_IDLE;
         r_dp  <= DP_IDLE;
         r_an  <= AN_IDLE;
      end else begin
         r_seg <= seg_apply_pol(w_blank ? SEG_BLANK : w_seg_raw, SEG_HI);
         r_dp  <= SEG_HI ? w_dp_on : ~w_dp_on;
         r_an  <= (AN_ACTIVE_HIGH != 0) ? w_onehot : ~w_onehot;
      end
   end

   assign seg_out    = r_seg;
   assign dp_out     = r_dp;
   assign an_out     = r_an;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: DIGITS=4, CLK_DIV=4, plus a second instance with inverted polarities.
module tb_seg_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        lz_blank;
   logic        load;

   logic [6:0]  seg_out,    seg_out_i;
   logic        dp_out,     dp_out_i;
   logic [3:0]  an_out,     an_out_i;
   logic        frame_done, frame_done_i;

   int checks = 0;
   int errors = 0;
   int k;

   logic [6:0] cap_seg [4];
   logic       cap_dp  [4];
   logic [3:0] cap_an  [4];
   logic [6:0] cap_seg_i [4];
   logic       cap_dp_i  [4];
   logic [3:0] cap_an_i  [4];

   localparam logic [3:0] AN_LOW  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   localparam logic [3:0] AN_HIGH [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

   seg_scan_driver #(
      .DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_HIGH(1), .AN_ACTIVE_HIGH(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
      .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
      .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
   );

   seg_scan_driver #(
      .DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_HIGH(0), .AN_ACTIVE_HIGH(1)
   ) dut_inv (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
      .digit_en(digit_en), .lz_blank(lz_blank), .load(load),
      .seg_out(seg_out_i), .dp_out(dp_out_i), .an_out(an_out_i), .frame_done(frame_done_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Posedges since reset release; phase k%16 locates the scan position
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic at_phase(input int p);
      int n;
      n = 0;
      step();
      while ((k % 16) != p && n < 40) begin
         step();
         n++;
      end
      if ((k % 16) != p) begin
         errors++;
         $display("FAIL at_phase timeout: phase %0d wanted %0d", k % 16, p);
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
      data_in  = d;
      dp_in    = dp;
      digit_en = en;
      load     = 1'b1;
      step();
      load     = 1'b0;
   endtask

   // Sample the middle of each digit slot of the next frame
   task automatic capture_frame();
      for (int d = 0; d < 4; d++) begin
         at_phase(4*d + 2);
         cap_seg[d]   = seg_out;
         cap_dp[d]    = dp_out;
         cap_an[d]    = an_out;
         cap_seg_i[d] = seg_out_i;
         cap_dp_i[d]  = dp_out_i;
         cap_an_i[d]  = an_out_i;
      end
   endtask

   task automatic test_reset();
      checks++; if (seg_out !== 7'h00) begin errors++; $display("FAIL reset seg: got %h want 00", seg_out); end
      checks++; if (an_out !== 4'hF) begin errors++; $display("FAIL reset an: got %h want F", an_out); end
      checks++; if (dp_out !== 1'b0) begin errors++; $display("FAIL reset dp: got %b want 0", dp_out); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
      checks++; if (seg_out_i !== 7'h7F) begin errors++; $display("FAIL reset inv seg: got %h want 7F", seg_out_i); end
      checks++; if (an_out_i !== 4'h0) begin errors++; $display("FAIL reset inv an: got %h want 0", an_out_i); end
      checks++; if (dp_out_i !== 1'b1) begin errors++; $display("FAIL reset inv dp: got %b want 1", dp_out_i); end
   endtask

   task automatic test_scan();
      int d;
      for (int n = 0; n < 32; n++) begin
         step();
         d = ((k - 1) / 4) % 4;
         checks++; if (an_out !== AN_LOW[d]) begin errors++; $display("FAIL scan an k=%0d: got %h want %h", k, an_out, AN_LOW[d]); end
         checks++; if (seg_out !== 7'h00) begin errors++; $display("FAIL scan seg k=%0d: got %h want 00", k, seg_out); end
         checks++; if (frame_done !== ((k % 16) == 15)) begin errors++; $display("FAIL scan frame_done k=%0d: got %b want %b", k, frame_done, (k % 16) == 15); end
      end
   endtask

   task automatic test_decode();
      logic [6:0] exp_seg [4];
      logic       exp_dp  [4];
      exp_seg = '{7'h71, 7'h77, 7'h5B, 7'h06};
      exp_dp  = '{1'b0, 1'b1, 1'b0, 1'b0};
      at_phase(1);
      do_load(16'h12AF, 4'b0010, 4'hF);
      capture_frame();
      for (int d = 0; d < 4; d++) begin
         checks++; if (cap_seg[d] !== exp_seg[d]) begin errors++; $display("FAIL decode seg d%0d: got %h want %h", d, cap_seg[d], exp_seg[d]); end
         checks++; if (cap_dp[d] !== exp_dp[d]) begin errors++; $display("FAIL decode dp d%0d: got %b want %b", d, cap_dp[d], exp_dp[d]); end
         checks++; if (cap_an[d] !== AN_LOW[d]) begin errors++; $display("FAIL decode an d%0d: got %h want %h", d, cap_an[d], AN_LOW[d]); end
      end
      checks++; if (cap_seg_i[0] !== 7'h0E) begin errors++; $display("FAIL decode inv seg d0: got %h want 0E", cap_seg_i[0]); end
   endtask

   task automatic test_lz_blank();
      logic [6:0] exp_seg [4];
      lz_blank = 1'b1;
      at_phase(1);
      do_load(16'h0050, 4'b0000, 4'hF);
      capture_frame();
      exp_seg = '{7'h3F, 7'h6D, 7'h00, 7'h00};
      for (int d = 0; d < 4; d++) begin
         checks++; if (cap_seg[d] !== exp_seg[d]) begin errors++; $display("FAIL lz_on seg d%0d: got %h want %h", d, cap_seg[d], exp_seg[d]); end
      end
      lz_blank = 1'b0;
      capture_frame();
      exp_seg = '{7'h3F, 7'h6D, 7'h3F, 7'h3F};
      for (int d = 0; d < 4; d++) begin
         checks++; if (cap_seg[d] !== exp_seg[d]) begin errors++; $display("FAIL lz_off seg d%0d: got %h want %h", d, cap_seg[d], exp_seg[d]); end
      end
      // Disabled top digit holds a non-zero nibble but must not stop the zero run
      lz_blank = 1'b1;
      at_phase(1);
      do_load(16'h5000, 4'b1001, 4'b0111);
      capture_frame();
      exp_seg = '{7'h3F, 7'h00, 7'h00, 7'h00};
      for (int d = 0; d < 4; d++) begin
         checks++; if (cap_seg[d] !== exp_seg[d]) begin errors++; $display("FAIL lz_dis seg d%0d: got %h want %h", d, cap_seg[d], exp_seg[d]); end
      end
      checks++; if (cap_dp[3] !== 1'b0) begin errors++; $display("FAIL lz_dis dp d3: got %b want 0", cap_dp[3]); end
      checks++; if (cap_dp[0] !== 1'b1) begin errors++; $display("FAIL lz_dis dp d0: got %b want 1", cap_dp[0]); end
      lz_blank = 1'b0;
   endtask

   task automatic test_back_to_back();
      at_phase(1);
      do_load(16'h1111, 4'b0000, 4'hF);
      at_phase(5);
      do_load(16'h2222, 4'b0000, 4'hF);
      // Current frame still shows 5000 / en 0111 with lz off
      at_phase(10);
      checks++; if (seg_out !== 7'h3F) begin errors++; $display("FAIL b2b current d2: got %h want 3F", seg_out); end
      at_phase(14);
      checks++; if (seg_out !== 7'h00) begin errors++; $display("FAIL b2b current d3: got %h want 00", seg_out); end
      capture_frame();
      for (int d = 0; d < 4; d++) begin
         checks++; if (cap_seg[d] !== 7'h5B) begin errors++; $display("FAIL b2b next d%0d: got %h want 5B", d, cap_seg[d]); end
      end
   endtask

   task automatic test_load_on_commit();
      at_phase(1);
      do_load(16'h3333, 4'b0000, 4'hF);
      at_phase(15);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL commit frame_done: got %b want 1", frame_done); end
      do_load(16'h4444, 4'b0000, 4'hF);
      capture_frame();
      for (int d = 0; d < 4; d++) begin
         checks++; if (cap_seg[d] !== 7'h4F) begin errors++; $display("FAIL commit frame1 d%0d: got %h want 4F", d, cap_seg[d]); end
      end
      capture_frame();
      for (int d = 0; d < 4; d++) begin
         checks++; if (cap_seg[d] !== 7'h66) begin errors++; $display("FAIL commit frame2 d%0d: got %h want 66", d, cap_seg[d]); end
      end
   endtask

   task automatic test_polarity();
      at_phase(1);
      do_load(16'h0008, 4'b0000, 4'hF);
      capture_frame();
      checks++; if (cap_seg_i[0] !== 7'h00) begin errors++; $display("FAIL pol inv seg d0: got %h want 00", cap_seg_i[0]); end
      checks++; if (cap_seg_i[1] !== 7'h40) begin errors++; $display("FAIL pol inv seg d1: got %h want 40", cap_seg_i[1]); end
      checks++; if (cap_dp_i[0] !== 1'b1) begin errors++; $display("FAIL pol inv dp d0: got %b want 1", cap_dp_i[0]); end
      checks++; if (cap_seg[0] !== 7'h7F) begin errors++; $display("FAIL pol norm seg d0: got %h want 7F", cap_seg[0]); end
      for (int d = 0; d < 4; d++) begin
         checks++; if (cap_an_i[d] !== AN_HIGH[d]) begin errors++; $display("FAIL pol inv an d%0d: got %h want %h", d, cap_an_i[d], AN_HIGH[d]); end
      end
   endtask

   task automatic test_reset_mid();
      at_phase(1);
      do_load(16'h9999, 4'b1111, 4'hF);
      at_phase(7);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (seg_out !== 7'h00) begin errors++; $display("FAIL midrst seg: got %h want 00", seg_out); end
      checks++; if (an_out !== 4'hF) begin errors++; $display("FAIL midrst an: got %h want F", an_out); end
      checks++; if (dp_out !== 1'b0) begin errors++; $display("FAIL midrst dp: got %b want 0", dp_out); end
      checks++; if (seg_out_i !== 7'h7F) begin errors++; $display("FAIL midrst inv seg: got %h want 7F", seg_out_i); end
      checks++; if (an_out_i !== 4'h0) begin errors++; $display("FAIL midrst inv an: got %h want 0", an_out_i); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (an_out !== 4'hE) begin errors++; $display("FAIL midrst restart an: got %h want E", an_out); end
      checks++; if (seg_out !== 7'h00) begin errors++; $display("FAIL midrst restart seg: got %h want 00", seg_out); end
      capture_frame();
      capture_frame();
      for (int d = 0; d < 4; d++) begin
         checks++; if (cap_seg[d] !== 7'h00) begin errors++; $display("FAIL midrst pending lost d%0d: got %h want 00", d, cap_seg[d]); end
         checks++; if (cap_dp[d] !== 1'b0) begin errors++; $display("FAIL midrst dp lost d%0d: got %b want 0", d, cap_dp[d]); end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      data_in  = '0;
      dp_in    = '0;
      digit_en = '0;
      lz_blank = 1'b0;
      load     = 1'b0;
      repeat (3) step();
      test_reset();
      rst_n = 1'b1;
      test_scan();
      test_decode();
      test_lz_blank();
      test_back_to_back();
      test_load_on_commit();
      test_polarity();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
